aes_block_serializer_16to4: RTL and testbench
=============================================

// Module: aes_block_serializer_16to4
// PURPOSE
//   Output-side width converter for the AES core: takes one 16-byte state block
//   (ciphertext/plaintext result) and emits it as NBEATS = NB_IN/NB_OUT words of NB_OUT bytes.
//   Mirrors the 4-to-16 input packer; sits between the AES round datapath and the host bus.
//   Two-entry (active + pending) buffer: the core can hand over the next block while
//   the current one drains.
// PARAMETERS
//   NB_IN      16  bytes per input block; must be an integer multiple of NB_OUT
//   NB_OUT     4   bytes per output word; NBEATS = NB_IN/NB_OUT, must be >= 2
//   WORD_ORDER 0   0: beat k carries bytes [k*NB_OUT +: NB_OUT]; 1: beat k carries bytes of word NBEATS-1-k
//   CNT_W      16  width of the completed-block counter
// PORTS
//   clk        in   1               clock, rising edge
//   resetn     in   1               reset, asynchronous, active-low
//   clear      in   1               synchronous flush of both buffer entries and the beat counter
//   in_valid   in   1               in_data holds a valid block
//   in_ready   out  1               block accepted on in_valid & in_ready
//   in_data    in   [NB_IN-1:0][7:0] input block, byte 0 = AES state byte 0
//   out_valid  out  1               out_data holds a valid word
//   out_ready  in   1               word consumed on out_valid & out_ready
//   out_data   out  [NB_OUT-1:0][7:0] output word
//   out_last   out  1               high with the final beat of a block
//   busy       out  1               at least one buffer entry occupied
//   blk_cnt    out  CNT_W           count of fully emitted blocks, wraps modulo 2^CNT_W
// BEHAVIOUR
//   - Reset (resetn=0): state=EMPTY, beat=0, both entries zeroed, blk_cnt=0.
//     Outputs: out_valid=0, out_last=0, out_data=0, busy=0.
//     in_ready=0 while resetn=0; in_ready=1 from the first clock edge after release.
//   - States:
//     EMPTY (no entry),
//     DRAIN (active loaded, pending free),
//     DRAIN_PEND (active and pending loaded).
//   - Outputs per state:
//     in_ready  = (state != DRAIN_PEND) && !clear.
//     out_valid = (state != EMPTY).
//     busy      = out_valid.
//   - out_data = active word selected by beat and WORD_ORDER; it is forced to 0 when out_valid=0.
//     out_last = out_valid && (beat == NBEATS-1).
//   - Latency: a block accepted in EMPTY at edge N has its beat 0 valid after edge N (one cycle).
//   - Stability: while out_valid && !out_ready, out_data and out_last must not change.
//   - Each out handshake increments beat.
//     Last-beat handshake: beat -> 0, blk_cnt += 1, then the active entry is refilled:
//     * from pending if DRAIN_PEND (-> DRAIN);
//     * else from in_data if an input handshake occurs the same cycle (stay DRAIN, no bubble);
//     * else -> EMPTY.
//   - In DRAIN, an input handshake without a last-beat handshake loads pending (-> DRAIN_PEND).
//   - In DRAIN_PEND, in_ready=0 and no input is taken, even in the cycle the last beat leaves.
//   - clear has priority over every handshake in the same cycle:
//     * -> EMPTY, beat=0, entries invalidated;
//     * a word presented that cycle is not counted;
//     * blk_cnt is preserved.
//   - Async reset mid-block discards both entries immediately. A partial block is never
//     resumed after reset or clear.
//   - Words leave in strict block order. No beat is skipped or duplicated under any
//     out_ready pattern.
//   - The input block is captured whole on its handshake. Later in_data changes do not
//     affect queued data.
// TESTING
//   1. Single block: in_data bytes 00..0F, out_ready=1, WORD_ORDER=0
//      -> words {03,02,01,00}..{0F,0E,0D,0C} (byte 0 in lane 0) on 4 consecutive cycles;
//         out_last on beat 3; blk_cnt=1.
//   2. Back-to-back: 3 blocks offered continuously, out_ready=1
//      -> 12 words with no idle cycle between blocks; in_ready drops only while both entries are full.
//   3. Backpressure: out_ready=0 for 5 cycles mid beat 1
//      -> out_data stable at beat 1. A second block fills pending, then in_ready=0.
//      -> After release, remaining beats of block 0 then all of block 1.
//   4. Last-beat + input same cycle, pending empty
//      -> new block's beat 0 appears the next cycle; blk_cnt increments once.
//   5. clear asserted during beat 2 with pending full
//      -> next cycle out_valid=0, busy=0, in_ready=1; blk_cnt unchanged; new block restarts at beat 0.
//   6. resetn pulsed low mid-drain
//      -> out_valid/out_last/out_data/busy/blk_cnt = 0 asynchronously; WORD_ORDER=1 rerun emits bytes 0C..0F first.

Source files
------------

// File: rtl/aes_block_serializer_16to4_if.sv
// aes_block_serializer_16to4_if
//   Stream bus between the AES core, the block serializer and the host side.
//   Input side carries whole NB_IN-byte blocks; output side carries NB_OUT-byte words.
//   Ports / signals:
//     in_valid, in_ready, in_data   block handshake (core -> serializer)
//     out_valid, out_ready,
//     out_data, out_last            word handshake (serializer -> host)
//   Modports:
//     master  drives the block input and consumes the word output
//     slave   the serializer itself
interface aes_block_serializer_16to4_if #(
  parameter int NB_IN  = 16,
  parameter int NB_OUT = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [NB_IN-1:0][7:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [NB_OUT-1:0][7:0] out_data;
  logic                   out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aes_block_serializer_16to4.sv
// aes_block_serializer_16to4
//   Output-side width converter for the AES core. Takes one NB_IN-byte state block
//   and emits it as NBEATS = NB_IN/NB_OUT words of NB_OUT bytes. A pending entry lets
//   the core hand over the next block while the current one drains.
//   Ports:
//     clk      clock, rising edge
//     resetn   asynchronous active-low reset
//     clear    synchronous flush of both entries and the beat counter (blk_cnt kept)
//     bus      slave side of the block/word stream interface
//     busy     at least one entry occupied
//     blk_cnt  number of fully emitted blocks, wraps modulo 2^CNT_W
//
//   state      | meaning
//   -----------+---------------------------------------
//   EMPTY      | no entry loaded
//   DRAIN      | active entry draining, pending free
//   DRAIN_PEND | active entry draining, pending loaded
module aes_block_serializer_16to4 #(
  parameter int NB_IN      = 16,
  parameter int NB_OUT     = 4,
  parameter int WORD_ORDER = 0,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        clear,
  aes_block_serializer_16to4_if.slave bus,
  output logic                        busy,
  output logic [CNT_W-1:0]            blk_cnt
);

  localparam int NBEATS = NB_IN / NB_OUT;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  typedef logic [NB_IN-1:0][7:0]          blk_t;
  typedef logic [NBEATS-1:0][NB_OUT*8-1:0] words_t;

  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    DRAIN      = 2'd1,
    DRAIN_PEND = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  blk_t              act_q, act_d;
  blk_t              pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q;

  logic              in_ready_i;
  logic              out_valid_i;
  logic              in_hs;
  logic              out_hs;
  logic              last_hs;
  words_t            act_words;
  logic [BEAT_W-1:0] word_idx;

  // rdy_q holds in_ready low until the first clock edge after reset release.
  assign in_ready_i  = rdy_q && (state_q != DRAIN_PEND) && !clear;
  assign out_valid_i = (state_q != EMPTY);
  assign in_hs       = bus.in_valid && in_ready_i;
  assign out_hs      = out_valid_i && bus.out_ready;
  assign last_hs     = out_hs && (beat_q == LAST_BEAT);

  assign act_words = act_q;
  assign word_idx  = (WORD_ORDER != 0) ? (LAST_BEAT - beat_q) : beat_q;

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = out_valid_i;
  assign bus.out_data  = out_valid_i ? act_words[word_idx] : '0;
  assign bus.out_last  = out_valid_i && (beat_q == LAST_BEAT);
  assign busy          = out_valid_i;
  assign blk_cnt       = cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
      beat_q  <= '0;
      act_q   <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    act_d   = act_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;

    // clear wins over both handshakes; the word shown this cycle is not counted.
    if (clear) begin
      state_d = EMPTY;
      beat_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_hs) begin
            act_d   = bus.in_data;
            beat_d  = '0;
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (last_hs) begin
            beat_d = '0;
            cnt_d  = cnt_q + 1'b1;
            // A block arriving with the last beat refills active directly: no bubble.
            if (in_hs) begin
              act_d = bus.in_data;
            end else begin
              state_d = EMPTY;
            end
          end else begin
            if (out_hs) begin
              beat_d = beat_q + 1'b1;
            end
            if (in_hs) begin
              pend_d  = bus.in_data;
              state_d = DRAIN_PEND;
            end
          end
        end
        DRAIN_PEND: begin
          if (last_hs) begin
            beat_d  = '0;
            cnt_d   = cnt_q + 1'b1;
            act_d   = pend_q;
            state_d = DRAIN;
          end else if (out_hs) begin
            beat_d = beat_q + 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
          beat_d  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_serializer_16to4.sv
// tb_aes_block_serializer_16to4
//   Directed bench for the 16-to-4 block serializer. Two instances (WORD_ORDER 0 and 1)
//   share one stimulus stream; a queue-of-words model predicts every output each cycle.
module tb_aes_block_serializer_16to4;
  localparam int NB_IN  = 16;
  localparam int NB_OUT = 4;
  localparam int NBEATS = NB_IN / NB_OUT;
  localparam int CNT_W  = 16;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic clear  = 1'b0;
  always #5 clk = ~clk;

  aes_block_serializer_16to4_if #(.NB_IN(NB_IN), .NB_OUT(NB_OUT)) bus0 ();
  aes_block_serializer_16to4_if #(.NB_IN(NB_IN), .NB_OUT(NB_OUT)) bus1 ();

  logic             busy0, busy1;
  logic [CNT_W-1:0] cnt0, cnt1;

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_data   = bus0.in_data;
  assign bus1.out_ready = bus0.out_ready;

  aes_block_serializer_16to4 #(.NB_IN(NB_IN), .NB_OUT(NB_OUT), .WORD_ORDER(0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .resetn(resetn), .clear(clear), .bus(bus0), .busy(busy0), .blk_cnt(cnt0)
  );
  aes_block_serializer_16to4 #(.NB_IN(NB_IN), .NB_OUT(NB_OUT), .WORD_ORDER(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .resetn(resetn), .clear(clear), .bus(bus1), .busy(busy1), .blk_cnt(cnt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mk(input logic [7:0] base);
    logic [127:0] b;
    for (int i = 0; i < NB_IN; i++) b[i*8 +: 8] = base + 8'(i);
    return b;
  endfunction

  function automatic logic [31:0] exp_word(input logic [127:0] b, input int beat, input int order);
    int w;
    w = (order != 0) ? (NBEATS - 1 - beat) : beat;
    return b[w*32 +: 32];
  endfunction

  // Model: every accepted block becomes NBEATS queue entries; the head is the word on
  // the bus. Occupied entries = ceil(words left / NBEATS).
  typedef struct {
    logic [127:0] blk;
    int           beat;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_cnt   = '0;
  logic        started = 1'b0;
  logic        has;
  logic        exp_rdy;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) started <= 1'b0;
    else         started <= 1'b1;
  end

  always @(negedge clk) begin
    if (!resetn) begin
      q.delete();
      m_cnt = '0;
      chk("rst_out_valid", bus0.out_valid, 0);
      chk("rst_in_ready", bus0.in_ready, 0);
      chk("rst_blk_cnt", cnt0, 0);
    end else begin
      has     = (q.size() != 0);
      exp_rdy = started && (((q.size() + NBEATS - 1) / NBEATS) < 2) && !clear;
      chk("out_valid", bus0.out_valid, has);
      chk("out_valid_wo1", bus1.out_valid, has);
      chk("busy", busy0, has);
      chk("in_ready", bus0.in_ready, exp_rdy);
      chk("in_ready_wo1", bus1.in_ready, exp_rdy);
      chk("blk_cnt", cnt0, m_cnt);
      chk("blk_cnt_wo1", cnt1, m_cnt);
      if (has) begin
        chk("out_data", bus0.out_data, exp_word(q[0].blk, q[0].beat, 0));
        chk("out_data_wo1", bus1.out_data, exp_word(q[0].blk, q[0].beat, 1));
        chk("out_last", bus0.out_last, q[0].beat == NBEATS - 1);
      end else begin
        chk("idle_out_data", bus0.out_data, 0);
        chk("idle_out_last", bus0.out_last, 0);
      end
      if (clear) begin
        q.delete();
      end else begin
        if (has && bus0.out_ready) begin
          if (q[0].beat == NBEATS - 1) m_cnt = m_cnt + 16'd1;
          void'(q.pop_front());
        end
        if (bus0.in_valid && exp_rdy) begin
          for (int k = 0; k < NBEATS; k++) q.push_back('{blk: bus0.in_data, beat: k});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a block until accepted; returns 1 time unit after the accepting edge.
  task automatic send_blk(input logic [127:0] b);
    int n;
    n = 0;
    bus0.in_valid = 1'b1;
    bus0.in_data  = b;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.in_ready && n < 50);
    chk("send_accept", bus0.in_ready, 1);
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    bus0.in_data  = {4{32'hDEADBEEF}};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus0.out_valid && n < 200);
    chk("drain_done", bus0.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus0.in_valid  = 1'b0;
    bus0.in_data   = '0;
    bus0.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_data", bus0.out_data, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_out_last", bus0.out_last, 0);
    step();
    resetn = 1'b1;

    // 1: single block
    bus0.out_ready = 1'b1;
    send_blk(mk(8'h00));
    @(negedge clk);
    chk("t1_beat0", bus0.out_data, 32'h03020100);
    chk("t1_beat0_wo1", bus1.out_data, 32'h0F0E0D0C);
    wait_idle();
    chk("t1_blk_cnt", cnt0, 1);

    // 2: back-to-back blocks
    step();
    send_blk(mk(8'h10));
    send_blk(mk(8'h20));
    send_blk(mk(8'h30));
    wait_idle();
    chk("t2_blk_cnt", cnt0, 4);

    // 3: backpressure during beat 1, second block fills pending
    step();
    bus0.out_ready = 1'b0;
    send_blk(mk(8'h00));
    bus0.out_ready = 1'b1;
    step();
    bus0.out_ready = 1'b0;
    send_blk(mk(8'h10));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_data", bus0.out_data, 32'h07060504);
      chk("t3_stall_last", bus0.out_last, 0);
      chk("t3_pend_full", bus0.in_ready, 0);
    end
    step();
    bus0.out_ready = 1'b1;
    wait_idle();
    chk("t3_blk_cnt", cnt0, 6);

    // 4: last beat and new block in the same cycle
    step();
    send_blk(mk(8'h50));
    repeat (3) step();
    send_blk(mk(8'h60));
    @(negedge clk);
    chk("t4_next_beat0", bus0.out_data, 32'h63626160);
    chk("t4_blk_cnt_once", cnt0, 7);
    wait_idle();
    chk("t4_blk_cnt", cnt0, 8);

    // 5: clear during beat 2 with pending full
    step();
    bus0.out_ready = 1'b0;
    send_blk(mk(8'h70));
    send_blk(mk(8'h80));
    bus0.out_ready = 1'b1;
    step();
    step();
    clear = 1'b1;
    @(negedge clk);
    chk("t5_clear_beat2", bus0.out_data, 32'h7B7A7978);
    chk("t5_clear_in_ready", bus0.in_ready, 0);
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", bus0.out_valid, 0);
    chk("t5_busy", busy0, 0);
    chk("t5_in_ready", bus0.in_ready, 1);
    chk("t5_blk_cnt", cnt0, 8);
    step();
    send_blk(mk(8'h90));
    @(negedge clk);
    chk("t5_restart_beat0", bus0.out_data, 32'h93929190);
    wait_idle();
    chk("t5_blk_cnt_after", cnt0, 9);

    // 6: async reset mid-drain, then WORD_ORDER=1 ordering
    step();
    bus0.out_ready = 1'b0;
    send_blk(mk(8'h00));
    bus0.out_ready = 1'b1;
    step();
    resetn = 1'b0;
    #1;
    chk("t6_out_valid", bus0.out_valid, 0);
    chk("t6_out_last", bus0.out_last, 0);
    chk("t6_out_data", bus0.out_data, 0);
    chk("t6_busy", busy0, 0);
    chk("t6_blk_cnt", cnt0, 0);
    chk("t6_out_valid_wo1", bus1.out_valid, 0);
    chk("t6_blk_cnt_wo1", cnt1, 0);
    step();
    resetn = 1'b1;
    send_blk(mk(8'h00));
    @(negedge clk);
    chk("t6_wo1_first", bus1.out_data, 32'h0F0E0D0C);
    chk("t6_wo0_first", bus0.out_data, 32'h03020100);
    wait_idle();
    chk("t6_blk_cnt_after", cnt1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
